// File: rtl/sgmii_pcs_tx_ratematch.sv
// SGMII PCS transmit ordered-set generator: idle, config and framed data
// with 10/100/1000 byte replication, one character slot per clock.
module sgmii_pcs_tx_ratematch #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_IPG      = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mode_cfg,
  input  logic [15:0] cfg_word,
  input  logic [1:0]  speed,
  input  logic        valid_in,
  output logic        ready_in,
  input  logic [7:0]  data_in,
  input  logic        eof_in,
  input  logic        tx_rd,
  output logic [7:0]  char_out,
  output logic        ctrl_out,
  output logic        even_out,
  output logic        underrun
);
  localparam logic [7:0] K_IDLE = 8'hBC;
  localparam logic [7:0] K_SOP  = 8'hFB;
  localparam logic [7:0] K_EOP  = 8'hFD;
  localparam logic [7:0] K_EXT  = 8'hF7;
  localparam logic [7:0] K_ERR  = 8'hFE;
  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 2);
  localparam logic [6:0] IPG_MAX  = 7'(MIN_IPG);

  typedef enum logic [3:0] {IDLE, CFG, SOF, PRE, SFD, DATA, ERR, EOT, EXT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  char_q, char_d;
  logic        ctrl_q, ctrl_d;
  logic        even_q;
  logic        underrun_q, underrun_d;
  logic [6:0]  rep_cnt_q, rep_cnt_d;
  logic [6:0]  rep_max_q, rep_max_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [6:0]  ipg_cnt_q, ipg_cnt_d;
  logic [7:0]  hold_q, hold_d;
  logic        eof_q, eof_d;
  logic [2:0]  cfg_pos_q, cfg_pos_d;
  logic [15:0] cfg_q, cfg_d;
  logic        rep_last, ipg_met;

  // rep_max holds the terminal count (REP-1) so no subtraction is needed
  assign rep_last = (rep_cnt_q == rep_max_q);
  assign ipg_met  = (ipg_cnt_q >= IPG_MAX);
  assign ready_in = rep_last && ((state_q == SFD) || (state_q == DATA && !eof_q));

  always_comb begin
    state_d    = state_q;
    rep_cnt_d  = rep_cnt_q;
    rep_max_d  = rep_max_q;
    pre_cnt_d  = pre_cnt_q;
    hold_d     = hold_q;
    eof_d      = eof_q;
    cfg_pos_d  = cfg_pos_q;
    cfg_d      = cfg_q;
    char_d     = K_IDLE;
    ctrl_d     = 1'b1;
    underrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (even_q) begin
          char_d = tx_rd ? 8'h50 : 8'hC5;
          ctrl_d = 1'b0;
        end else if (mode_cfg) begin
          state_d   = CFG;
          cfg_pos_d = 3'd0;
          cfg_d     = cfg_word;
        end else if (valid_in && ipg_met) begin
          state_d = SOF;
          char_d  = K_SOP;
          case (speed)
            2'b00:   rep_max_d = 7'd99;
            2'b01:   rep_max_d = 7'd9;
            default: rep_max_d = 7'd0;
          endcase
        end
      end
      CFG: begin
        if (!even_q && !mode_cfg) begin
          state_d = IDLE;
        end else begin
          cfg_pos_d = cfg_pos_q + 3'd1;
          if (cfg_pos_d[1:0] == 2'd0) cfg_d = cfg_word;
          case (cfg_pos_d[1:0])
            2'd0:    begin char_d = K_IDLE; ctrl_d = 1'b1; end
            2'd1:    begin char_d = cfg_pos_d[2] ? 8'h42 : 8'hB5; ctrl_d = 1'b0; end
            2'd2:    begin char_d = cfg_d[7:0]; ctrl_d = 1'b0; end
            default: begin char_d = cfg_d[15:8]; ctrl_d = 1'b0; end
          endcase
        end
      end
      SOF: begin
        state_d   = PRE;
        rep_cnt_d = 7'd0;
        pre_cnt_d = 4'd0;
        char_d    = 8'h55;
        ctrl_d    = 1'b0;
      end
      PRE: begin
        char_d = 8'h55;
        ctrl_d = 1'b0;
        if (rep_last) begin
          rep_cnt_d = 7'd0;
          if (pre_cnt_q == PRE_LAST) begin
            state_d = SFD;
            char_d  = 8'hD5;
          end else begin
            pre_cnt_d = pre_cnt_q + 4'd1;
          end
        end else begin
          rep_cnt_d = rep_cnt_q + 7'd1;
        end
      end
      SFD, DATA: begin
        char_d = (state_q == SFD) ? 8'hD5 : hold_q;
        ctrl_d = 1'b0;
        if (!rep_last) begin
          rep_cnt_d = rep_cnt_q + 7'd1;
        end else if (state_q == DATA && eof_q) begin
          state_d = EOT;
          char_d  = K_EOP;
          ctrl_d  = 1'b1;
        end else if (valid_in) begin
          state_d   = DATA;
          hold_d    = data_in;
          eof_d     = eof_in;
          rep_cnt_d = 7'd0;
          char_d    = data_in;
        end else begin
          // MAC failed to supply a byte when asked: abort with /V/
          state_d    = ERR;
          char_d     = K_ERR;
          ctrl_d     = 1'b1;
          underrun_d = 1'b1;
        end
      end
      ERR: begin
        state_d = EOT;
        char_d  = K_EOP;
      end
      EOT: begin
        state_d = EXT;
        char_d  = K_EXT;
      end
      EXT: begin
        // a second /R/ when needed so IDLE resumes on an even slot
        if (even_q) char_d = K_EXT;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ipg_cnt_d = (state_d == EOT) ? 7'd0 : (ipg_met ? IPG_MAX : ipg_cnt_q + 7'd1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      char_q     <= K_IDLE;
      ctrl_q     <= 1'b1;
      even_q     <= 1'b1;
      underrun_q <= 1'b0;
      rep_cnt_q  <= 7'd0;
      rep_max_q  <= 7'd0;
      pre_cnt_q  <= 4'd0;
      ipg_cnt_q  <= IPG_MAX;
      hold_q     <= 8'd0;
      eof_q      <= 1'b0;
      cfg_pos_q  <= 3'd0;
      cfg_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      char_q     <= char_d;
      ctrl_q     <= ctrl_d;
      even_q     <= ~even_q;
      underrun_q <= underrun_d;
      rep_cnt_q  <= rep_cnt_d;
      rep_max_q  <= rep_max_d;
      pre_cnt_q  <= pre_cnt_d;
      ipg_cnt_q  <= ipg_cnt_d;
      hold_q     <= hold_d;
      eof_q      <= eof_d;
      cfg_pos_q  <= cfg_pos_d;
      cfg_q      <= cfg_d;
    end
  end

  assign char_out = char_q;
  assign ctrl_out = ctrl_q;
  assign even_out = even_q;
  assign underrun = underrun_q;
endmodule
